// File: rtl/alu_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_scheduler_if
// Purpose  : Bundles the decoder->scheduler instruction handshake, the issue
//            pulse, the writeback strobes and the drain handshake of the ALU
//            issue scheduler into one interface.
// Ports    : master - decoder / control side (drives instruction + drain)
//            slave  - scheduler side (drives ready, issue, writeback, status)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_scheduler_if #(
    parameter int SEL_W   = 4,
    parameter int STALL_W = 16
) ();
    // Instruction handshake
    logic               in_valid;
    logic               in_ready;
    logic               in_const_a;
    logic [SEL_W-1:0]   in_a_sel;
    logic [SEL_W-1:0]   in_b_sel;
    logic [SEL_W-1:0]   in_c_sel;
    logic [SEL_W-1:0]   in_d_sel;
    logic [SEL_W-1:0]   in_y1_sel;
    logic [SEL_W-1:0]   in_y2_sel;
    logic [1:0]         in_write;
    // Issue / writeback
    logic               issue_valid;
    logic [1:0]         wb_valid;
    logic [SEL_W-1:0]   wb_y1_sel;
    logic [SEL_W-1:0]   wb_y2_sel;
    // Drain handshake and status
    logic               drain;
    logic               drained;
    logic [STALL_W-1:0] stall_count;

    modport master (
        output in_valid, in_const_a, in_a_sel, in_b_sel, in_c_sel, in_d_sel,
               in_y1_sel, in_y2_sel, in_write, drain,
        input  in_ready, issue_valid, wb_valid, wb_y1_sel, wb_y2_sel,
               drained, stall_count
    );

    modport slave (
        input  in_valid, in_const_a, in_a_sel, in_b_sel, in_c_sel, in_d_sel,
               in_y1_sel, in_y2_sel, in_write, drain,
        output in_ready, issue_valid, wb_valid, wb_y1_sel, wb_y2_sel,
               drained, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_scheduler
// Purpose  : Issue controller between the ALU decoder and the ALU datapath.
//            Keeps a per-register pending scoreboard, stalls instructions with
//            RAW/WAW hazards, issues the rest, emits writeback strobes a fixed
//            ALU_LATENCY cycles after issue and supports a drain handshake.
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous active-high reset
//            sched_io    - slave modport of alu_issue_scheduler_if:
//                          in_* instruction handshake, issue_valid pulse,
//                          wb_valid/wb_y1_sel/wb_y2_sel writeback,
//                          drain/drained handshake, saturating stall_count
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_scheduler #(
    parameter int SEL_W       = 4,
    parameter int ALU_LATENCY = 3,
    parameter int STALL_W     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_issue_scheduler_if.slave sched_io
);

    localparam int                 NREG      = 2**SEL_W;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic               drained_q;
    logic [NREG-1:0]    pending_q;
    logic [NREG-1:0]    pending_d;
    logic [STALL_W-1:0] stall_q;

    // Writeback pipeline: stage 0 is loaded at the end of the transfer cycle,
    // stage ALU_LATENCY-1 is the one presented as the writeback.
    logic [1:0]         pipe_w_q  [ALU_LATENCY];
    logic [SEL_W-1:0]   pipe_y1_q [ALU_LATENCY];
    logic [SEL_W-1:0]   pipe_y2_q [ALU_LATENCY];

    logic               w_raw;
    logic               w_waw;
    logic               w_hazard;
    logic               w_ready;
    logic               w_xfer;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_clr;
    logic               w_pipe_busy;
    logic               w_empty_next;
    logic [1:0]         w_wb_w;
    logic [SEL_W-1:0]   w_wb_y1;
    logic [SEL_W-1:0]   w_wb_y2;

    assign w_wb_w  = pipe_w_q[ALU_LATENCY-1];
    assign w_wb_y1 = pipe_y1_q[ALU_LATENCY-1];
    assign w_wb_y2 = pipe_y2_q[ALU_LATENCY-1];

    // ------------------------------------------------------------------------
    // Hazard check and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        w_raw = pending_q[sched_io.in_b_sel]
              | pending_q[sched_io.in_c_sel]
              | pending_q[sched_io.in_d_sel]
              | (!sched_io.in_const_a && pending_q[sched_io.in_a_sel]);
        w_waw = (sched_io.in_write[0] && pending_q[sched_io.in_y1_sel])
              | (sched_io.in_write[1] && pending_q[sched_io.in_y2_sel]);
        w_hazard = sched_io.in_valid && (w_raw || w_waw);
        // drain wins over a transfer in the first cycle it is seen
        w_ready  = !rst && (state_q == ST_RUN) && !sched_io.drain && !w_hazard;
        w_xfer   = sched_io.in_valid && w_ready;
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state: clears from the writeback stage, sets from the
    // new issue. Set is applied last so it wins on a collision.
    // ------------------------------------------------------------------------
    always_comb begin
        w_clr = '0;
        if (w_wb_w[0]) w_clr[w_wb_y1] = 1'b1;
        if (w_wb_w[1]) w_clr[w_wb_y2] = 1'b1;

        w_set = '0;
        if (w_xfer && sched_io.in_write[0]) w_set[sched_io.in_y1_sel] = 1'b1;
        if (w_xfer && sched_io.in_write[1]) w_set[sched_io.in_y2_sel] = 1'b1;

        pending_d = (pending_q & ~w_clr) | w_set;
    end

    // Writes still travelling towards the writeback stage after this edge.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < ALU_LATENCY - 1; i++) begin
            w_pipe_busy = w_pipe_busy | (|pipe_w_q[i]);
        end
        w_empty_next = (pending_d == '0) && !w_pipe_busy;
    end

    // ------------------------------------------------------------------------
    // State, scoreboard, writeback pipeline and stall counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
            pending_q <= '0;
            stall_q   <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                pipe_w_q[i]  <= 2'b00;
                pipe_y1_q[i] <= '0;
                pipe_y2_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;

            pipe_w_q[0]  <= w_xfer ? sched_io.in_write  : 2'b00;
            pipe_y1_q[0] <= w_xfer ? sched_io.in_y1_sel : '0;
            pipe_y2_q[0] <= w_xfer ? sched_io.in_y2_sel : '0;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                pipe_w_q[i]  <= pipe_w_q[i-1];
                pipe_y1_q[i] <= pipe_y1_q[i-1];
                pipe_y2_q[i] <= pipe_y2_q[i-1];
            end

            if ((state_q == ST_RUN) && sched_io.in_valid && !w_ready &&
                (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_ONE;
            end

            case (state_q)
                ST_RUN: begin
                    if (sched_io.drain) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!sched_io.drain) begin
                        state_q <= ST_RUN;
                    end else if (w_empty_next) begin
                        // emptiness is judged on the post-edge scoreboard so
                        // drained rises the cycle after the last writeback
                        state_q   <= ST_DONE;
                        drained_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!sched_io.drain) begin
                        state_q   <= ST_RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (held at zero while reset is asserted)
    // ------------------------------------------------------------------------
    assign sched_io.in_ready    = w_ready;
    assign sched_io.issue_valid = w_xfer;
    assign sched_io.wb_valid    = rst ? 2'b00 : w_wb_w;
    assign sched_io.wb_y1_sel   = rst ? '0 : w_wb_y1;
    assign sched_io.wb_y2_sel   = rst ? '0 : w_wb_y2;
    assign sched_io.drained     = drained_q && !rst;
    assign sched_io.stall_count = rst ? '0 : stall_q;

    // A register being retired while re-issued means the WAW check failed.
    a_set_clr_disjoint: assert property (
        @(posedge clk) disable iff (rst) ((w_set & w_clr) == '0)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_scheduler
// Purpose  : Self-checking bench for alu_issue_scheduler. A reference model of
//            in-flight writes (list of {due cycle, writes, y1, y2}) predicts the
//            handshake, status outputs and the writeback stream; a separate
//            monitor pops expected writebacks from a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_scheduler;

    localparam int SEL_W     = 4;
    localparam int LAT       = 3;
    localparam int STALL_W   = 16;
    localparam int STALL_MAX = (1 << STALL_W) - 1;
    localparam int WAIT_MAX  = 100;

    typedef struct {
        int               due;
        logic [1:0]       w;
        logic [SEL_W-1:0] y1;
        logic [SEL_W-1:0] y2;
    } wb_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   passed = 0;
    int   total  = 0;

    wb_t  inflight[$];
    wb_t  exp_q[$];
    int   mode = 0;               // 0 run, 1 draining, 2 drained
    int   m_stall = 0;

    alu_issue_scheduler_if #(.SEL_W(SEL_W), .STALL_W(STALL_W)) ifc ();

    alu_issue_scheduler #(
        .SEL_W       (SEL_W),
        .ALU_LATENCY (LAT),
        .STALL_W     (STALL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_io (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic bit is_pending(input logic [SEL_W-1:0] r);
        foreach (inflight[i]) begin
            if ((inflight[i].w[0] && inflight[i].y1 == r) ||
                (inflight[i].w[1] && inflight[i].y2 == r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: handshake, issue, drain status, stall counter
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        bit  haz, rdy, busy;
        wb_t e;
        if (rst) begin
            check("rst_in_ready", ifc.in_ready, 0);
            check("rst_issue", ifc.issue_valid, 0);
            check("rst_drained", ifc.drained, 0);
            check("rst_stall", ifc.stall_count, 0);
            inflight.delete();
            mode    = 0;
            m_stall = 0;
        end else begin
            while (inflight.size() > 0 && inflight[0].due < cyc) void'(inflight.pop_front());
            haz = ifc.in_valid &&
                  (is_pending(ifc.in_b_sel) || is_pending(ifc.in_c_sel) ||
                   is_pending(ifc.in_d_sel) ||
                   (!ifc.in_const_a && is_pending(ifc.in_a_sel)) ||
                   (ifc.in_write[0] && is_pending(ifc.in_y1_sel)) ||
                   (ifc.in_write[1] && is_pending(ifc.in_y2_sel)));
            rdy = (mode == 0) && !ifc.drain && !haz;
            check("in_ready", ifc.in_ready, rdy);
            check("issue_valid", ifc.issue_valid, ifc.in_valid && rdy);
            check("drained", ifc.drained, mode == 2);
            check("stall_count", ifc.stall_count, m_stall);
            if (ifc.in_valid && rdy && ifc.in_write != 2'b00) begin
                e.due = cyc + LAT;
                e.w   = ifc.in_write;
                e.y1  = ifc.in_y1_sel;
                e.y2  = ifc.in_y2_sel;
                inflight.push_back(e);
                exp_q.push_back(e);
            end
            if (mode == 0 && ifc.in_valid && !rdy && m_stall < STALL_MAX) m_stall++;
            busy = 1'b0;
            foreach (inflight[i]) if (inflight[i].due > cyc) busy = 1'b1;
            case (mode)
                0: if (ifc.drain) mode = 1;
                1: if (!ifc.drain) mode = 0; else if (!busy) mode = 2;
                default: if (!ifc.drain) mode = 0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Writeback monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        wb_t e;
        if (rst) begin
            check("rst_wb_valid", ifc.wb_valid, 0);
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("wb_valid", ifc.wb_valid, e.w);
            if (e.w[0]) check("wb_y1_sel", ifc.wb_y1_sel, e.y1);
            if (e.w[1]) check("wb_y2_sel", ifc.wb_y2_sel, e.y2);
        end else begin
            check("wb_idle", ifc.wb_valid, 0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic set_instr(input logic ca, input int a, input int b, input int c,
                             input int d, input int y1, input int y2, input logic [1:0] w);
        ifc.in_valid   = 1'b1;
        ifc.in_const_a = ca;
        ifc.in_a_sel   = SEL_W'(a);
        ifc.in_b_sel   = SEL_W'(b);
        ifc.in_c_sel   = SEL_W'(c);
        ifc.in_d_sel   = SEL_W'(d);
        ifc.in_y1_sel  = SEL_W'(y1);
        ifc.in_y2_sel  = SEL_W'(y2);
        ifc.in_write   = w;
    endtask

    task automatic wait_xfer();
        int k = 0;
        @(negedge clk);
        while (!ifc.in_ready && k < WAIT_MAX) begin
            k++;
            @(negedge clk);
        end
        check("xfer_timeout", k >= WAIT_MAX, 0);
    endtask

    task automatic send(input logic ca, input int a, input int b, input int c,
                        input int d, input int y1, input int y2, input logic [1:0] w);
        @(posedge clk); #1;
        set_instr(ca, a, b, c, d, y1, y2, w);
        wait_xfer();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ifc.in_valid = 1'b0;
        end
    endtask

    function automatic int rsel();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                           : int'($urandom_range(0, 5));
    endfunction

    initial begin
        int r, k;
        rst       = 1'b1;
        ifc.drain = 1'b0;
        set_instr(0, 1, 2, 3, 4, 5, 6, 2'b11);
        repeat (3) @(posedge clk);
        #1;
        rst          = 1'b0;
        ifc.in_valid = 1'b0;

        // basic issue and writeback timing
        send(0, 1, 2, 3, 4, 5, 0, 2'b01);
        idle(6);
        // RAW on b
        send(0, 0, 0, 0, 0, 5, 0, 2'b01);
        send(0, 0, 5, 0, 0, 6, 0, 2'b01);
        idle(6);
        // constant operand A skips the check; non-constant stalls
        send(0, 0, 0, 0, 0, 5, 0, 2'b01);
        send(1, 5, 1, 1, 1, 6, 0, 2'b01);
        idle(6);
        send(0, 0, 0, 0, 0, 5, 0, 2'b01);
        send(0, 5, 1, 1, 1, 6, 0, 2'b01);
        idle(6);
        // WAW on y2, then y1==y2 double write
        send(0, 0, 0, 0, 0, 0, 7, 2'b10);
        send(0, 1, 1, 1, 1, 0, 7, 2'b10);
        idle(6);
        send(0, 0, 0, 0, 0, 9, 9, 2'b11);
        idle(6);
        // drain with two instructions in flight, then resume
        send(0, 0, 0, 0, 0, 3, 0, 2'b01);
        send(0, 0, 0, 0, 0, 4, 0, 2'b01);
        @(posedge clk); #1;
        set_instr(0, 1, 1, 1, 1, 8, 0, 2'b01);
        ifc.drain = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        ifc.drain = 1'b0;
        wait_xfer();
        idle(6);
        // drain on an empty pipeline
        @(posedge clk); #1;
        ifc.drain = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ifc.drain = 1'b0;
        idle(3);
        // reset one cycle after issue
        send(0, 0, 0, 0, 0, 10, 11, 2'b11);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                @(posedge clk); #1;
                ifc.in_valid = 1'b0;
                ifc.drain    = 1'b1;
                k = int'($urandom_range(1, 12));
                repeat (k) @(posedge clk);
                #1;
                ifc.drain = 1'b0;
            end else if (r < 6) begin
                @(posedge clk); #1;
                ifc.in_valid = 1'b0;
                rst = 1'b1;
                k = int'($urandom_range(1, 2));
                repeat (k) @(posedge clk);
                #1;
                rst = 1'b0;
            end else if (r < 20) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                send(1'($urandom_range(0, 1)), rsel(), rsel(), rsel(), rsel(),
                     rsel(), rsel(), 2'($urandom_range(0, 3)));
            end
        end
        idle(12);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
